// File: rtl/mips_pkg.sv
// Shared constants for the MIPS decode/execute slice.
// Holds the opcode and funct encodings, the ALU operation codes, the
// write-back and destination-register selects, and the operand-A selects.
// This file has no ports.
package mips_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // ALU operation codes
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_NOR  = 5'd5;
  localparam logic [4:0] ALU_SLT  = 5'd6;
  localparam logic [4:0] ALU_SLTU = 5'd7;
  localparam logic [4:0] ALU_SLL  = 5'd8;
  localparam logic [4:0] ALU_SRL  = 5'd9;
  localparam logic [4:0] ALU_SRA  = 5'd10;
  localparam logic [4:0] ALU_EQ   = 5'd11;
  localparam logic [4:0] ALU_NE   = 5'd12;

  // Write-back select
  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MEM = 2'd1;
  localparam logic [1:0] M2R_PC4 = 2'd2;

  // Destination register select
  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  // Operand A select
  localparam logic [1:0] ASEL_RS    = 2'd0;
  localparam logic [1:0] ASEL_LUI   = 2'd1;
  localparam logic [1:0] ASEL_SHAMT = 2'd2;

  // LUI is executed as SLL of the immediate by this constant
  localparam logic [31:0] LUI_SHIFT = 32'd16;

endpackage

// File: rtl/mips_alu.sv
// Combinational 32-bit ALU with zero and signed-overflow flags.
// Ports:
//   a_i      in  32  operand A (shift amount for shift ops, in a_i[4:0])
//   b_i      in  32  operand B (value shifted for shift ops)
//   op_i     in  5   ALU operation code (mips_pkg ALU_*)
//   result_o out 32  result; codes without a defined operation give 0
//   zero_o   out 1   result_o == 0
//   ovf_o    out 1   signed overflow, meaningful for ADD/SUB only
module mips_alu
  import mips_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [4:0]  op_i,
  output logic [31:0] result_o,
  output logic        zero_o,
  output logic        ovf_o
);

  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic [31:0]        sum;
  logic [31:0]        diff;

  assign a_s  = a_i;
  assign b_s  = b_i;
  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;

  always_comb begin
    result_o = '0;
    ovf_o    = 1'b0;
    case (op_i)
      ALU_ADD: begin
        result_o = sum;
        // Same-sign operands producing a result of the other sign
        ovf_o    = (a_i[31] == b_i[31]) && (sum[31] != a_i[31]);
      end
      ALU_SUB: begin
        result_o = diff;
        ovf_o    = (a_i[31] != b_i[31]) && (diff[31] != a_i[31]);
      end
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_NOR:  result_o = ~(a_i | b_i);
      ALU_SLT:  result_o = {31'b0, (a_s < b_s)};
      ALU_SLTU: result_o = {31'b0, (a_i < b_i)};
      ALU_SLL:  result_o = b_i << a_i[4:0];
      ALU_SRL:  result_o = b_i >> a_i[4:0];
      ALU_SRA:  result_o = $unsigned(b_s >>> a_i[4:0]);
      ALU_EQ:   result_o = {31'b0, (a_i == b_i)};
      ALU_NE:   result_o = {31'b0, (a_i != b_i)};
      default:  result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/mips_decode_execute.sv
// Registered decode/execute slice of a single-cycle MIPS datapath:
// main control decode, 16->32 immediate extension, operand muxes and ALU,
// all captured in one output register (one cycle from instr to result).
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   instr         instruction word
//   rs_data       register-file read of instr[25:21]
//   rt_data       register-file read of instr[20:16]
//   alu_result    registered ALU result
//   zero          registered (alu_result == 0)
//   overflow      registered signed overflow of ADD, SUB, ADDI
//   ext_imm       registered extended immediate
//   wr_reg        registered destination register (rt, rd or 31)
//   alu_op        registered ALU operation code
//   mem2reg       write-back select (0 ALU, 1 memory, 2 PC+4)
//   reg_wr        register-file write enable
//   mem_wr        data-memory write enable
module mips_decode_execute
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic        overflow,
  output logic [31:0] ext_imm,
  output logic [4:0]  wr_reg,
  output logic [4:0]  alu_op,
  output logic [1:0]  mem2reg,
  output logic        reg_wr,
  output logic        mem_wr
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt_f;
  logic [4:0]  rd_f;
  logic [4:0]  shamt;
  logic [15:0] imm;

  assign opcode = instr[31:26];
  assign rt_f   = instr[20:16];
  assign rd_f   = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];

  // The rs field only addresses the register file upstream.
  logic unused_rs_field;
  assign unused_rs_field = &{1'b0, instr[25:21]};

  // Decoded control
  logic [4:0] alu_op_dec;
  logic [1:0] dst_sel;
  logic [1:0] m2r_dec;
  logic [1:0] a_sel;
  logic       b_is_rt;
  logic       zext;
  logic       ovf_en;
  logic       reg_wr_dec;
  logic       mem_wr_dec;

  always_comb begin
    alu_op_dec = ALU_ADD;
    dst_sel    = DST_RT;
    m2r_dec    = M2R_ALU;
    a_sel      = ASEL_RS;
    b_is_rt    = 1'b0;
    zext       = 1'b0;
    ovf_en     = 1'b0;
    reg_wr_dec = 1'b0;
    mem_wr_dec = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        b_is_rt    = 1'b1;
        dst_sel    = DST_RD;
        reg_wr_dec = 1'b1;
        case (funct)
          FN_ADD:  ovf_en = 1'b1;
          FN_ADDU: alu_op_dec = ALU_ADD;
          FN_SUB:  begin alu_op_dec = ALU_SUB; ovf_en = 1'b1; end
          FN_SUBU: alu_op_dec = ALU_SUB;
          FN_AND:  alu_op_dec = ALU_AND;
          FN_OR:   alu_op_dec = ALU_OR;
          FN_XOR:  alu_op_dec = ALU_XOR;
          FN_NOR:  alu_op_dec = ALU_NOR;
          FN_SLT:  alu_op_dec = ALU_SLT;
          FN_SLTU: alu_op_dec = ALU_SLTU;
          FN_SLL:  begin alu_op_dec = ALU_SLL; a_sel = ASEL_SHAMT; end
          FN_SRL:  begin alu_op_dec = ALU_SRL; a_sel = ASEL_SHAMT; end
          FN_SRA:  begin alu_op_dec = ALU_SRA; a_sel = ASEL_SHAMT; end
          FN_SLLV: alu_op_dec = ALU_SLL;
          FN_SRLV: alu_op_dec = ALU_SRL;
          FN_SRAV: alu_op_dec = ALU_SRA;
          FN_JR:   reg_wr_dec = 1'b0;
          default: reg_wr_dec = 1'b0;  // unknown funct behaves as a NOP
        endcase
      end
      OP_ADDI:  begin reg_wr_dec = 1'b1; ovf_en = 1'b1; end
      OP_ADDIU: reg_wr_dec = 1'b1;
      OP_SLTI:  begin reg_wr_dec = 1'b1; alu_op_dec = ALU_SLT; end
      OP_SLTIU: begin reg_wr_dec = 1'b1; alu_op_dec = ALU_SLTU; end
      OP_ANDI:  begin reg_wr_dec = 1'b1; alu_op_dec = ALU_AND; zext = 1'b1; end
      OP_ORI:   begin reg_wr_dec = 1'b1; alu_op_dec = ALU_OR;  zext = 1'b1; end
      OP_XORI:  begin reg_wr_dec = 1'b1; alu_op_dec = ALU_XOR; zext = 1'b1; end
      OP_LUI:   begin reg_wr_dec = 1'b1; alu_op_dec = ALU_SLL; a_sel = ASEL_LUI; end
      OP_LW:    begin reg_wr_dec = 1'b1; m2r_dec = M2R_MEM; end
      OP_SW:    mem_wr_dec = 1'b1;
      OP_BEQ:   begin alu_op_dec = ALU_EQ; b_is_rt = 1'b1; end
      OP_BNE:   begin alu_op_dec = ALU_NE; b_is_rt = 1'b1; end
      OP_J:     alu_op_dec = ALU_ADD;
      OP_JAL:   begin reg_wr_dec = 1'b1; dst_sel = DST_RA; m2r_dec = M2R_PC4; end
      default:  alu_op_dec = ALU_ADD;  // unknown opcode behaves as a NOP
    endcase
  end

  // Extension, operand selection and ALU
  logic [31:0] ext_imm_d;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_res;
  logic        alu_zero;
  logic        alu_ovf;
  logic [4:0]  wr_reg_d;

  assign ext_imm_d = zext ? {16'b0, imm} : {{16{imm[15]}}, imm};

  always_comb begin
    case (a_sel)
      ASEL_LUI:   op_a = LUI_SHIFT;
      ASEL_SHAMT: op_a = {27'b0, shamt};
      default:    op_a = rs_data;
    endcase
  end

  assign op_b = b_is_rt ? rt_data : ext_imm_d;

  mips_alu u_alu (
    .a_i      (op_a),
    .b_i      (op_b),
    .op_i     (alu_op_dec),
    .result_o (alu_res),
    .zero_o   (alu_zero),
    .ovf_o    (alu_ovf)
  );

  always_comb begin
    case (dst_sel)
      DST_RD:  wr_reg_d = rd_f;
      DST_RA:  wr_reg_d = 5'd31;
      default: wr_reg_d = rt_f;
    endcase
  end

  // Output register stage
  logic [31:0] alu_result_q;
  logic        zero_q;
  logic        overflow_q;
  logic [31:0] ext_imm_q;
  logic [4:0]  wr_reg_q;
  logic [4:0]  alu_op_q;
  logic [1:0]  mem2reg_q;
  logic        reg_wr_q;
  logic        mem_wr_q;

  logic [31:0] alu_result_d;
  logic        zero_d;
  logic        overflow_d;
  logic [4:0]  alu_op_d;
  logic [1:0]  mem2reg_d;
  logic        reg_wr_d;
  logic        mem_wr_d;

  always_comb begin
    alu_result_d = alu_res;
    zero_d       = alu_zero;
    // ADDU/SUBU/ADDIU/LW/SW also use the adder but never flag overflow
    overflow_d   = ovf_en & alu_ovf;
    alu_op_d     = alu_op_dec;
    mem2reg_d    = m2r_dec;
    reg_wr_d     = reg_wr_dec;
    mem_wr_d     = mem_wr_dec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result_q <= '0;
      zero_q       <= 1'b0;
      overflow_q   <= 1'b0;
      ext_imm_q    <= '0;
      wr_reg_q     <= '0;
      alu_op_q     <= '0;
      mem2reg_q    <= '0;
      reg_wr_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
    end else begin
      alu_result_q <= alu_result_d;
      zero_q       <= zero_d;
      overflow_q   <= overflow_d;
      ext_imm_q    <= ext_imm_d;
      wr_reg_q     <= wr_reg_d;
      alu_op_q     <= alu_op_d;
      mem2reg_q    <= mem2reg_d;
      reg_wr_q     <= reg_wr_d;
      mem_wr_q     <= mem_wr_d;
    end
  end

  assign alu_result = alu_result_q;
  assign zero       = zero_q;
  assign overflow   = overflow_q;
  assign ext_imm    = ext_imm_q;
  assign wr_reg     = wr_reg_q;
  assign alu_op     = alu_op_q;
  assign mem2reg    = mem2reg_q;
  assign reg_wr     = reg_wr_q;
  assign mem_wr     = mem_wr_q;

endmodule

// File: tb/tb_mips_decode_execute.sv
// Scoreboard bench for mips_decode_execute: the driver pushes a hand-computed
// expectation per issued instruction, the monitor pops and compares one cycle
// later on the falling edge.
module tb_mips_decode_execute;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic [31:0] alu_result;
  logic        zero;
  logic        overflow;
  logic [31:0] ext_imm;
  logic [4:0]  wr_reg;
  logic [4:0]  alu_op;
  logic [1:0]  mem2reg;
  logic        reg_wr;
  logic        mem_wr;

  always #5 clk = ~clk;

  mips_decode_execute dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .alu_result (alu_result),
    .zero       (zero),
    .overflow   (overflow),
    .ext_imm    (ext_imm),
    .wr_reg     (wr_reg),
    .alu_op     (alu_op),
    .mem2reg    (mem2reg),
    .reg_wr     (reg_wr),
    .mem_wr     (mem_wr)
  );

  // Mask bits selecting which fields a vector checks
  localparam logic [8:0] M_RES = 9'h001, M_Z = 9'h002, M_OV = 9'h004,
                         M_EXT = 9'h008, M_WR = 9'h010, M_OP = 9'h020,
                         M_M2R = 9'h040, M_RW = 9'h080, M_MW = 9'h100;
  localparam logic [8:0] M_ALL = 9'h1FF;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        z;
    logic        ov;
    logic [31:0] ext;
    logic [4:0]  wr;
    logic [4:0]  op;
    logic [1:0]  m2r;
    logic        rw;
    logic        mw;
    logic [8:0]  mask;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic issue_vld = 1'b0;
  logic vld_p1 = 1'b0;

  always @(posedge clk) vld_p1 <= issue_vld;

  function automatic logic [31:0] rt_i(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sh,
                                       input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] it_i(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic issue(input int id, input logic r, input logic [31:0] ins,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] res, input logic z, input logic ov,
                       input logic [31:0] ext, input logic [4:0] wr,
                       input logic [4:0] op, input logic [1:0] m2r,
                       input logic rw, input logic mw, input logic [8:0] mask);
    exp_t e;
    @(posedge clk);
    #1;
    rst     = r;
    instr   = ins;
    rs_data = rs;
    rt_data = rt;
    e.id = id; e.res = res; e.z = z; e.ov = ov; e.ext = ext; e.wr = wr;
    e.op = op; e.m2r = m2r; e.rw = rw; e.mw = mw; e.mask = mask;
    exp_q.push_back(e);
    issue_vld = 1'b1;
  endtask

  task automatic chk(input int id, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL vec%0d %s: got 0x%08h expected 0x%08h", id, name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (vld_p1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard: output with no expectation queued");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.mask[0]) chk(e.id, "alu_result", alu_result, e.res);
        if (e.mask[1]) chk(e.id, "zero", {31'b0, zero}, {31'b0, e.z});
        if (e.mask[2]) chk(e.id, "overflow", {31'b0, overflow}, {31'b0, e.ov});
        if (e.mask[3]) chk(e.id, "ext_imm", ext_imm, e.ext);
        if (e.mask[4]) chk(e.id, "wr_reg", {27'b0, wr_reg}, {27'b0, e.wr});
        if (e.mask[5]) chk(e.id, "alu_op", {27'b0, alu_op}, {27'b0, e.op});
        if (e.mask[6]) chk(e.id, "mem2reg", {30'b0, mem2reg}, {30'b0, e.m2r});
        if (e.mask[7]) chk(e.id, "reg_wr", {31'b0, reg_wr}, {31'b0, e.rw});
        if (e.mask[8]) chk(e.id, "mem_wr", {31'b0, mem_wr}, {31'b0, e.mw});
      end
    end
  end

  initial begin
    //    id rst instr                         rs            rt            res           z  ov ext           wr  op  m2r rw mw mask
    issue(1, 1, rt_i(1, 2, 3, 0, 6'h20),       32'd5,        32'd7,        32'd0,        0, 0, 32'h0,      5'd0,  5'd0,  2'd0, 0, 0, M_ALL);
    issue(2, 0, rt_i(1, 2, 3, 0, 6'h21),       32'd5,        32'd7,        32'd12,       0, 0, 32'h1821,   5'd3,  5'd0,  2'd0, 1, 0, M_ALL);
    issue(3, 0, it_i(6'h0F, 0, 4, 16'h1234),   32'hDEAD,     32'h0,        32'h12340000, 0, 0, 32'h1234,   5'd4,  5'd8,  2'd0, 1, 0, M_ALL);
    issue(4, 0, it_i(6'h0D, 4, 4, 16'h8001),   32'h12340000, 32'h0,        32'h12348001, 0, 0, 32'h8001,   5'd4,  5'd3,  2'd0, 1, 0, M_ALL);
    issue(5, 0, rt_i(0, 6, 5, 4, 6'h03),       32'h1F,       32'h80000000, 32'hF8000000, 0, 0, 32'h2903,   5'd5,  5'd10, 2'd0, 1, 0, M_ALL);
    issue(6, 0, rt_i(1, 2, 7, 0, 6'h06),       32'd4,        32'h80000000, 32'h08000000, 0, 0, 32'h3806,   5'd7,  5'd9,  2'd0, 1, 0, M_ALL);
    issue(7, 0, rt_i(1, 2, 3, 0, 6'h20),       32'h7FFFFFFF, 32'd1,        32'h80000000, 0, 1, 32'h1820,   5'd3,  5'd0,  2'd0, 1, 0, M_ALL);
    issue(8, 0, rt_i(1, 2, 3, 0, 6'h21),       32'h7FFFFFFF, 32'd1,        32'h80000000, 0, 0, 32'h1821,   5'd3,  5'd0,  2'd0, 1, 0, M_ALL);
    issue(9, 0, rt_i(1, 2, 3, 0, 6'h22),       32'h80000000, 32'd1,        32'h7FFFFFFF, 0, 1, 32'h1822,   5'd3,  5'd1,  2'd0, 1, 0, M_ALL);
    issue(10, 0, rt_i(1, 2, 3, 0, 6'h2A),      32'hFFFFFFFF, 32'd1,        32'd1,        0, 0, 32'h182A,   5'd3,  5'd6,  2'd0, 1, 0, M_ALL);
    issue(11, 0, rt_i(1, 2, 3, 0, 6'h2B),      32'hFFFFFFFF, 32'd1,        32'd0,        1, 0, 32'h182B,   5'd3,  5'd7,  2'd0, 1, 0, M_ALL);
    issue(12, 0, it_i(6'h08, 1, 5, 16'h0001),  32'h7FFFFFFF, 32'd0,        32'h80000000, 0, 1, 32'h1,      5'd5,  5'd0,  2'd0, 1, 0, M_ALL);
    issue(13, 0, it_i(6'h23, 1, 2, 16'hFFFC),  32'h100,      32'hABC,      32'hFC,       0, 0, 32'hFFFFFFFC, 5'd2, 5'd0,  2'd1, 1, 0, M_ALL);
    issue(14, 0, it_i(6'h2B, 1, 2, 16'hFFFC),  32'h100,      32'hABC,      32'hFC,       0, 0, 32'hFFFFFFFC, 5'd0, 5'd0,  2'd0, 0, 1, M_ALL & ~M_WR);
    issue(15, 0, it_i(6'h04, 1, 2, 16'h0010),  32'd9,        32'd9,        32'd1,        0, 0, 32'h10,     5'd0,  5'd11, 2'd0, 0, 0, M_ALL & ~M_WR);
    issue(16, 0, it_i(6'h05, 1, 2, 16'h0010),  32'd9,        32'd9,        32'd0,        1, 0, 32'h10,     5'd0,  5'd12, 2'd0, 0, 0, M_ALL & ~M_WR);
    issue(17, 0, {6'h03, 26'h0000040},         32'h0,        32'h0,        32'd0,        0, 0, 32'h40,     5'd31, 5'd0,  2'd2, 1, 0, M_EXT | M_WR | M_M2R | M_RW | M_MW);
    issue(18, 0, {6'h02, 26'h0000040},         32'h0,        32'h0,        32'd0,        0, 0, 32'h0,      5'd0,  5'd0,  2'd0, 0, 0, M_M2R | M_RW | M_MW);
    issue(19, 0, it_i(6'h3F, 1, 2, 16'h0001),  32'h7FFFFFFF, 32'h0,        32'd0,        0, 0, 32'h0,      5'd0,  5'd0,  2'd0, 0, 0, M_OV | M_OP | M_RW | M_MW);
    issue(20, 0, rt_i(1, 2, 3, 0, 6'h3F),      32'd1,        32'd2,        32'd0,        0, 0, 32'h0,      5'd0,  5'd0,  2'd0, 0, 0, M_OP | M_RW | M_MW);
    issue(21, 0, rt_i(31, 0, 0, 0, 6'h08),     32'h400,      32'h0,        32'd0,        0, 0, 32'h0,      5'd0,  5'd0,  2'd0, 0, 0, M_OP | M_RW | M_MW);
    issue(22, 0, 32'h0,                        32'h0,        32'h55,       32'h55,       0, 0, 32'h0,      5'd0,  5'd8,  2'd0, 1, 0, M_ALL);
    issue(23, 1, rt_i(1, 2, 3, 0, 6'h20),      32'h7FFFFFFF, 32'd1,        32'd0,        0, 0, 32'h0,      5'd0,  5'd0,  2'd0, 0, 0, M_ALL);
    issue(24, 0, rt_i(1, 2, 3, 0, 6'h21),      32'd5,        32'd7,        32'd12,       0, 0, 32'h1821,   5'd3,  5'd0,  2'd0, 1, 0, M_ALL);
    @(posedge clk);
    #1;
    issue_vld = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
